clink_frame_packer: RTL
=======================

// Module: clink_frame_packer
// PURPOSE
//  Sits between the Camera Link 7:1 deserializer and the DRAM write DMA. Consumes per-clock
//  FVAL/LVAL/DVAL plus pixel words and packs IN_WIDTH-bit words into OUT_WIDTH-bit AXI-Stream
//  beats. Marks the first beat of a frame with tuser and the last beat with tlast, pulses
//  image_end when a frame has fully left the block, and flags geometry errors and overflow.
// PARAMETERS
//  IN_WIDTH   16    pixel bits per deserialized clock; must divide OUT_WIDTH
//  OUT_WIDTH  128   output beat width; R = OUT_WIDTH/IN_WIDTH words per beat (default 8)
//  H_ACTIVE   1024  expected words per line
//  V_ACTIVE   64    expected lines per frame; H_ACTIVE*V_ACTIVE must be a multiple of R
// PORTS
//  clk_pixel        in   1          pixel clock (deserializer parallel clock)
//  clk_pixel_reset  in   1          synchronous, active-high reset
//  capture_en       in   1          arm capture of frames
//  fval/lval/dval   in   1 each     Camera Link frame/line/data valid
//  pix_data         in   IN_WIDTH   pixel word; sampled only when fval&lval&dval
//  m_axis_tdata     out  OUT_WIDTH  packed beat; word 0 in bits [IN_WIDTH-1:0]
//  m_axis_tvalid    out  1          beat valid
//  m_axis_tready    in   1          downstream ready
//  m_axis_tuser     out  1          first beat of frame
//  m_axis_tlast     out  1          last beat of frame
//  image_end        out  1          1-cycle pulse on tlast handshake
//  frame_count      out  16         frames completed; wraps 0xFFFF->0
//  size_err         out  1          sticky: line or frame length mismatch
//  overflow_err     out  1          sticky: beat dropped because output buffer full
//  busy             out  1          state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, counters 0, state IDLE. Reset mid-frame discards the
//    partial frame; no tlast and no image_end are produced for it.
//  - FSM: IDLE -> WAIT_FV when capture_en=1 and fval=0 (capture never starts mid-frame).
//    WAIT_FV -> ACTIVE on fval=1. ACTIVE -> FLUSH on fval falling. FLUSH -> WAIT_FV when the
//    tlast beat is pushed and capture_en=1; else -> IDLE. capture_en=0 mid-frame completes
//    the current frame normally.
//  - Packing: in ACTIVE, each qualified word is placed in lane wptr (0..R-1), and wptr
//    increments. At lane R-1 the beat is pushed into a 2-entry output FIFO. The beat is
//    visible on m_axis_tvalid the cycle after the R-th word is sampled.
//  - Word counter total is 0..H_ACTIVE*V_ACTIVE-1. The beat holding word
//    H_ACTIVE*V_ACTIVE-1 carries tlast. Further words in the same frame are discarded and set
//    size_err.
//  - Short frame (fval falls before the total is reached): in FLUSH the partial beat is
//    zero-padded in its unused high lanes and pushed with tlast, and size_err is set. If
//    wptr=0 and no tlast was sent, an all-zero beat with tlast is pushed.
//  - Line check: on lval falling in ACTIVE, if the per-line count != H_ACTIVE, size_err is
//    set; packing continues. The line counter resets per line.
//  - FIFO: push and pop in the same cycle are both allowed when full. A push while full with
//    no pop drops the new beat and sets overflow_err. A dropped tlast beat forces a
//    replacement tlast-only beat on the next free slot, so frame framing is never lost.
//  - AXI-S: tdata, tuser and tlast are stable while tvalid=1 and tready=0. tvalid never
//    depends combinationally on tready.
//  - image_end and the frame_count increment occur in the same cycle as the tlast handshake.
//  - size_err and overflow_err clear only on reset.
// TESTING
//  1. H=16, V=2, R=8, tready=1, incrementing words 0..31 -> 4 beats.
//     Beat0 = words 0..7 with tuser=1. Beat3 has tlast=1. image_end pulses once.
//     frame_count=1. No error flags.
//  2. Same frame with tready held 0 for 40 cycles -> overflow_err=1.
//     tlast is still delivered after tready=1.
//  3. fval falls after 20 words -> beat2 = words 16..19 plus 4 zero lanes, with tlast=1.
//     size_err=1.
//  4. Line of 15 words (lval early) -> size_err=1. Packing stays continuous across lines.
//  5. capture_en raised while fval=1 -> no output until the next full frame.
//     Reset asserted mid-frame -> tvalid=0 next cycle, with no image_end.
//  6. Three back-to-back frames with capture_en dropped during frame 2
//     -> frames 1 and 2 complete, frame 3 is ignored, frame_count=2.

Source files
------------

// File: rtl/clink_frame_packer_if.sv
// AXI-Stream beat bus from the Camera Link packer to the DRAM write DMA.
// The master owns data/valid/user/last; the slave owns ready.
interface clink_frame_packer_if #(
    parameter int DW = 128
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/clink_frame_packer.sv
// Packs Camera Link pixel words into AXI-S beats; a beat appears one cycle after its last word.
// A 2-entry output FIFO absorbs backpressure; beats arriving while it is full are dropped and flagged.
module clink_frame_packer #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 128,
    parameter int H_ACTIVE  = 1024,
    parameter int V_ACTIVE  = 64
) (
    input  logic                clk_pixel,
    input  logic                clk_pixel_reset,
    input  logic                capture_en,
    input  logic                fval,
    input  logic                lval,
    input  logic                dval,
    input  logic [IN_WIDTH-1:0] pix_data,
    clink_frame_packer_if.master m_axis,
    output logic                image_end,
    output logic [15:0]         frame_count,
    output logic                size_err,
    output logic                overflow_err,
    output logic                busy
);
    localparam int R     = OUT_WIDTH / IN_WIDTH;
    localparam int LW    = (R > 1) ? $clog2(R) : 1;
    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int WCW   = $clog2(TOTAL) + 1;
    localparam int LCW   = $clog2(H_ACTIVE) + 2;
    localparam logic [LW-1:0]  LAST_LANE = LW'(R - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(TOTAL - 1);
    localparam logic [LCW-1:0] LINE_LEN  = LCW'(H_ACTIVE);
    localparam logic [LCW-1:0] LINE_MAX  = '1;

    typedef enum logic [1:0] {IDLE, WAIT_FV, ACTIVE, FLUSH} state_t;

    typedef struct packed {
        logic                 tuser;
        logic                 tlast;
        logic [OUT_WIDTH-1:0] data;
    } beat_t;

    state_t               state_q, state_d;
    logic [OUT_WIDTH-1:0] beat_q, beat_d;
    logic [LW-1:0]        wptr_q, wptr_d;
    logic [WCW-1:0]       word_cnt_q, word_cnt_d;
    logic [LCW-1:0]       line_cnt_q, line_cnt_d;
    logic                 done_q, done_d;
    logic                 first_q, first_d;
    logic                 pend_q, pend_d;
    logic                 size_err_q, size_err_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 lval_q;

    beat_t                mem_q [2];
    logic                 rd_q, wr_q;
    logic [1:0]           cnt_q, cnt_d;

    beat_t                cand, fifo_dat;
    logic                 cand_vld, fifo_push, accept, pop, full;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        wptr_d     = wptr_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        done_d     = done_q;
        first_d    = first_q;
        size_err_d = size_err_q;
        cand_vld   = 1'b0;
        cand       = '0;

        if (state_q == IDLE || state_q == WAIT_FV) begin
            beat_d     = '0;
            wptr_d     = '0;
            word_cnt_d = '0;
            line_cnt_d = '0;
            done_d     = 1'b0;
            first_d    = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (capture_en && !fval) state_d = WAIT_FV;
            end
            WAIT_FV: begin
                if (!capture_en)  state_d = IDLE;
                else if (fval)    state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!fval) state_d = FLUSH;
                if (fval && lval && dval) begin
                    if (line_cnt_q != LINE_MAX) line_cnt_d = line_cnt_q + LCW'(1);
                    // Words past the frame's tlast beat are surplus and only flag the error.
                    if (done_q) begin
                        size_err_d = 1'b1;
                    end else begin
                        beat_d[int'(wptr_q)*IN_WIDTH +: IN_WIDTH] = pix_data;
                        wptr_d     = wptr_q + LW'(1);
                        word_cnt_d = word_cnt_q + WCW'(1);
                        if (wptr_q == LAST_LANE) begin
                            cand_vld   = 1'b1;
                            cand.data  = beat_d;
                            cand.tuser = first_q;
                            cand.tlast = (word_cnt_q == LAST_WORD);
                            done_d     = (word_cnt_q == LAST_WORD);
                            first_d    = 1'b0;
                            beat_d     = '0;
                            wptr_d     = '0;
                        end
                    end
                end
                if (lval_q && !lval) begin
                    if (line_cnt_q != LINE_LEN) size_err_d = 1'b1;
                    line_cnt_d = '0;
                end
            end
            FLUSH: begin
                state_d = capture_en ? WAIT_FV : IDLE;
                // Short frame: unused lanes are already zero because beat_q clears on every push.
                if (!done_q) begin
                    cand_vld   = 1'b1;
                    cand.data  = beat_q;
                    cand.tuser = first_q;
                    cand.tlast = 1'b1;
                    size_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop       = m_axis.tvalid && m_axis.tready;
        full      = (cnt_q == 2'd2);
        fifo_push = pend_q || cand_vld;
        fifo_dat  = cand;
        if (pend_q) begin
            fifo_dat       = '0;
            fifo_dat.tlast = 1'b1;
        end
        accept = fifo_push && (!full || pop);
        cnt_d  = cnt_q + (accept ? 2'd1 : 2'd0) - (pop ? 2'd1 : 2'd0);
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (pend_q && accept) pend_d = 1'b0;
        if (fifo_push && !accept) begin
            ovf_d = 1'b1;
            if (fifo_dat.tlast) pend_d = 1'b1;
        end
        // The replacement tlast owns the slot; a packer beat in the same cycle is lost.
        if (pend_q && cand_vld) begin
            ovf_d = 1'b1;
            if (cand.tlast) pend_d = 1'b1;
        end
        frame_cnt_d = frame_cnt_q;
        if (image_end) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_pixel) begin
        if (clk_pixel_reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            wptr_q      <= '0;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
            done_q      <= 1'b0;
            first_q     <= 1'b1;
            pend_q      <= 1'b0;
            size_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
            lval_q      <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wptr_q      <= wptr_d;
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
            done_q      <= done_d;
            first_q     <= first_d;
            pend_q      <= pend_d;
            size_err_q  <= size_err_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
            lval_q      <= lval;
            cnt_q       <= cnt_d;
            if (accept) begin
                mem_q[wr_q] <= fifo_dat;
                wr_q        <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
        end
    end

    assign m_axis.tvalid = (cnt_q != 2'd0);
    assign m_axis.tdata  = mem_q[rd_q].data;
    assign m_axis.tuser  = mem_q[rd_q].tuser;
    assign m_axis.tlast  = mem_q[rd_q].tlast;
    assign image_end     = pop && mem_q[rd_q].tlast;
    assign frame_count   = frame_cnt_q;
    assign size_err      = size_err_q;
    assign overflow_err  = ovf_q;
    assign busy          = (state_q != IDLE);
endmodule
